keypad_matrix_responder: RTL and testbench

- Synthesizable responder for the 4x4 matrix keypad interface: plays the keypad side against the column-scanning keypad reader.
- Accepts "press key N" requests through a valid/ready handshake.
- Emulates contact bounce, hold and release, and answers the reader's active-low column strobes by pulling the matching row low.
- Used for board-less demos and as the stimulus source in keypad-to-register/PC integration benches.

---
 rtl/keypad_matrix_responder.sv | 178 +++++++++++++++++
 tb/tb_keypad_matrix_responder.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_matrix_responder.sv
// Emulates the key side of a 4x4 active-low matrix keypad for a column-scanning reader.
// Latency: contact closes the cycle after a request is accepted; KEY_R follows KEY_C/contact one cycle later.
// Backpressure: req_ready only in IDLE; requests seen while busy are dropped, never queued.
//
// Ports:
//   clk, clr             clock and asynchronous active-high reset
//   req_valid/req_key    press request; req_key[3:2]=row, req_key[1:0]=column
//   req_ready, busy      handshake ready (IDLE only) and its complement
//   KEY_C                active-low column strobes from the reader
//   KEY_R                registered active-low row lines back to the reader
//   contact              emulated contact state (1 = closed)
//   done                 one-cycle pulse in the last GAP cycle of a press
module keypad_matrix_responder #(
  parameter int unsigned BOUNCE_CYCLES = 4,
  parameter int unsigned BOUNCE_TOGGLE = 1,
  parameter int unsigned HOLD_CYCLES   = 8,
  parameter int unsigned GAP_CYCLES    = 3,
  parameter int unsigned CNT_W         = 16
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       req_valid,
  input  logic [3:0] req_key,
  output logic       req_ready,
  input  logic [3:0] KEY_C,
  output logic [3:0] KEY_R,
  output logic       contact,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_BOUNCE_IN,
    S_HOLD,
    S_BOUNCE_OUT,
    S_GAP
  } state_t;

  // Counters hold "cycles remaining minus one", so zero marks the last cycle of a phase.
  localparam logic [CNT_W-1:0] LD_BOUNCE = CNT_W'(BOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LD_TOG    = CNT_W'(BOUNCE_TOGGLE - 1);
  localparam logic [CNT_W-1:0] LD_HOLD   = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] LD_GAP    = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
  localparam bit               HAS_BOUNCE = (BOUNCE_CYCLES != 0);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_tcnt;
  logic             r_contact;
  logic [3:0]       r_key;
  logic [3:0]       r_key_r;

  state_t           w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0] w_tcnt_nxt;
  logic             w_contact_nxt;
  logic             w_accept;
  logic [3:0]       w_row_nxt;

  assign w_accept = req_valid && (r_state == S_IDLE);

  // Next-state, phase counter and contact waveform.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_tcnt_nxt    = r_tcnt;
    w_contact_nxt = r_contact;

    unique case (r_state)
      S_IDLE: begin
        w_contact_nxt = 1'b0;
        if (w_accept) begin
          w_contact_nxt = 1'b1;
          w_tcnt_nxt    = LD_TOG;
          if (HAS_BOUNCE) begin
            w_state_nxt = S_BOUNCE_IN;
            w_cnt_nxt   = LD_BOUNCE;
          end else begin
            w_state_nxt = S_HOLD;
            w_cnt_nxt   = LD_HOLD;
          end
        end
      end

      S_BOUNCE_IN, S_BOUNCE_OUT: begin
        if (r_cnt == '0) begin
          if (r_state == S_BOUNCE_IN) begin
            w_state_nxt   = S_HOLD;
            w_cnt_nxt     = LD_HOLD;
            w_contact_nxt = 1'b1;
          end else begin
            w_state_nxt   = S_GAP;
            w_cnt_nxt     = LD_GAP;
            w_contact_nxt = 1'b0;
          end
        end else begin
          w_cnt_nxt = r_cnt - ONE;
          // Toggle divider: invert the contact every BOUNCE_TOGGLE cycles.
          if (r_tcnt == '0) begin
            w_contact_nxt = ~r_contact;
            w_tcnt_nxt    = LD_TOG;
          end else begin
            w_tcnt_nxt = r_tcnt - ONE;
          end
        end
      end

      S_HOLD: begin
        if (r_cnt == '0) begin
          w_contact_nxt = 1'b0;
          w_tcnt_nxt    = LD_TOG;
          if (HAS_BOUNCE) begin
            w_state_nxt = S_BOUNCE_OUT;
            w_cnt_nxt   = LD_BOUNCE;
          end else begin
            w_state_nxt = S_GAP;
            w_cnt_nxt   = LD_GAP;
          end
        end else begin
          w_cnt_nxt = r_cnt - ONE;
        end
      end

      S_GAP: begin
        w_contact_nxt = 1'b0;
        if (r_cnt == '0) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt - ONE;
        end
      end

      default: begin
        w_state_nxt   = S_IDLE;
        w_cnt_nxt     = '0;
        w_contact_nxt = 1'b0;
      end
    endcase
  end

  // Row drive uses the contact and strobes as they stand at the edge, hence one cycle of latency.
  always_comb begin
    w_row_nxt = 4'b1111;
    if (r_contact && !KEY_C[r_key[1:0]]) begin
      w_row_nxt[r_key[3:2]] = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_tcnt    <= '0;
      r_contact <= 1'b0;
      r_key     <= 4'h0;
      r_key_r   <= 4'b1111;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_tcnt    <= w_tcnt_nxt;
      r_contact <= w_contact_nxt;
      r_key_r   <= w_row_nxt;
      if (w_accept) begin
        r_key <= req_key;
      end
    end
  end

  assign req_ready = (r_state == S_IDLE);
  assign busy      = ~req_ready;
  assign done      = (r_state == S_GAP) && (r_cnt == '0);
  assign contact   = r_contact;
  assign KEY_R     = r_key_r;

endmodule

// File: tb/tb_keypad_matrix_responder.sv
// Bench for keypad_matrix_responder: three instances with different bounce/hold/gap
// settings share one stimulus stream; a cycle-indexed reference model predicts every output.
module tb_keypad_matrix_responder;

  logic       clk = 1'b0;
  logic       clr;
  logic       req_valid;
  logic [3:0] req_key;
  logic [3:0] key_c;

  logic [3:0] key_r     [3];
  logic       contact_o [3];
  logic       ready_o   [3];
  logic       busy_o    [3];
  logic       done_o    [3];

  always #5 clk = ~clk;

  keypad_matrix_responder #(.BOUNCE_CYCLES(0), .BOUNCE_TOGGLE(1), .HOLD_CYCLES(8), .GAP_CYCLES(3)) dut0 (
    .clk(clk), .clr(clr), .req_valid(req_valid), .req_key(req_key), .req_ready(ready_o[0]),
    .KEY_C(key_c), .KEY_R(key_r[0]), .contact(contact_o[0]), .busy(busy_o[0]), .done(done_o[0]));

  keypad_matrix_responder #(.BOUNCE_CYCLES(4), .BOUNCE_TOGGLE(1), .HOLD_CYCLES(8), .GAP_CYCLES(3)) dut1 (
    .clk(clk), .clr(clr), .req_valid(req_valid), .req_key(req_key), .req_ready(ready_o[1]),
    .KEY_C(key_c), .KEY_R(key_r[1]), .contact(contact_o[1]), .busy(busy_o[1]), .done(done_o[1]));

  keypad_matrix_responder #(.BOUNCE_CYCLES(3), .BOUNCE_TOGGLE(2), .HOLD_CYCLES(2), .GAP_CYCLES(1)) dut2 (
    .clk(clk), .clr(clr), .req_valid(req_valid), .req_key(req_key), .req_ready(ready_o[2]),
    .KEY_C(key_c), .KEY_R(key_r[2]), .contact(contact_o[2]), .busy(busy_o[2]), .done(done_o[2]));

  int checks = 0;
  int errors = 0;

  // Reference model: a press is a numbered sequence of busy cycles 0..total-1.
  bit         m_busy    [3];
  int         m_idx     [3];
  logic [3:0] m_key     [3];
  bit         m_contact [3];
  logic [3:0] m_keyr    [3];
  int         exp_dones [3];
  int         obs_dones [3];

  function automatic int pb(int i);
    case (i) 0: return 0; 1: return 4; default: return 3; endcase
  endfunction
  function automatic int pt(int i);
    case (i) 0: return 1; 1: return 1; default: return 2; endcase
  endfunction
  function automatic int ph(int i);
    case (i) 0: return 8; 1: return 8; default: return 2; endcase
  endfunction
  function automatic int pg(int i);
    case (i) 0: return 3; 1: return 3; default: return 1; endcase
  endfunction
  function automatic int total(int i);
    return 2 * pb(i) + ph(i) + pg(i);
  endfunction

  // Contact level in busy cycle k of a press.
  function automatic bit contact_at(int i, int k);
    int kk;
    kk = k;
    if (kk < pb(i)) return ((kk / pt(i)) % 2) == 0;
    kk -= pb(i);
    if (kk < ph(i)) return 1'b1;
    kk -= ph(i);
    if (kk < pb(i)) return ((kk / pt(i)) % 2) == 1;
    return 1'b0;
  endfunction

  function automatic bit m_done(int i);
    return m_busy[i] && (m_idx[i] == total(i) - 1);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_busy[i]    = 1'b0;
      m_idx[i]     = 0;
      m_key[i]     = 4'h0;
      m_contact[i] = 1'b0;
      m_keyr[i]    = 4'b1111;
    end
  endtask

  task automatic model_edge();
    logic [3:0] nk;
    if (clr) begin
      model_reset();
      return;
    end
    for (int i = 0; i < 3; i++) begin
      nk = 4'b1111;
      if (m_contact[i] && !key_c[m_key[i][1:0]]) nk[m_key[i][3:2]] = 1'b0;
      m_keyr[i] = nk;
      if (!m_busy[i]) begin
        if (req_valid) begin
          m_busy[i] = 1'b1;
          m_idx[i]  = 0;
          m_key[i]  = req_key;
        end
      end else begin
        m_idx[i]++;
        if (m_idx[i] >= total(i)) m_busy[i] = 1'b0;
      end
      m_contact[i] = m_busy[i] ? contact_at(i, m_idx[i]) : 1'b0;
    end
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(string phase);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("%s_i%0d_key_r", phase, i), {28'd0, key_r[i]}, {28'd0, m_keyr[i]});
      chk($sformatf("%s_i%0d_contact", phase, i), {31'd0, contact_o[i]}, {31'd0, m_contact[i]});
      chk($sformatf("%s_i%0d_ready", phase, i), {31'd0, ready_o[i]}, {31'd0, !m_busy[i]});
      chk($sformatf("%s_i%0d_busy", phase, i), {31'd0, busy_o[i]}, {31'd0, m_busy[i]});
      chk($sformatf("%s_i%0d_done", phase, i), {31'd0, done_o[i]}, {31'd0, m_done(i)});
      if (done_o[i] === 1'b1) obs_dones[i]++;
      if (m_done(i)) exp_dones[i]++;
    end
  endtask

  task automatic tick(string phase);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all(phase);
  endtask

  // Accept one press, then measure cycles until each instance is ready again.
  task automatic press_and_time(logic [3:0] key, logic [3:0] cols, string phase);
    int lat [3];
    req_key   = key;
    key_c     = cols;
    req_valid = 1'b1;
    tick(phase);
    req_valid = 1'b0;
    for (int i = 0; i < 3; i++) lat[i] = -1;
    for (int n = 1; n <= 30; n++) begin
      tick(phase);
      for (int i = 0; i < 3; i++) if (lat[i] < 0 && ready_o[i] === 1'b1) lat[i] = n;
    end
    for (int i = 0; i < 3; i++)
      chk($sformatf("%s_i%0d_latency", phase, i), lat[i], total(i));
  endtask

  initial begin
    clr       = 1'b0;
    req_valid = 1'b0;
    req_key   = 4'h0;
    key_c     = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      exp_dones[i] = 0;
      obs_dones[i] = 0;
    end

    // Asynchronous reset, observed before any clock edge.
    #2 clr = 1'b1;
    #1 model_reset();
    check_all("reset");
    @(negedge clk);
    clr = 1'b0;
    tick("idle");

    // Row 1, column 2 with the matching column strobed; then column mismatch.
    press_and_time(4'h6, 4'b1011, "basic");
    press_and_time(4'h6, 4'b0111, "mismatch");
    // Row 0, column 0 with bounce visible on the bouncing instances.
    press_and_time(4'h0, 4'b1110, "bounce");
    // Several columns strobed at once, matching column among them.
    press_and_time(4'hB, 4'b0001, "multicol");

    // Handshake: request held high with changing keys while busy.
    req_valid = 1'b1;
    for (int n = 0; n < 60; n++) begin
      req_key = 4'($urandom_range(0, 15));
      key_c   = 4'($urandom_range(0, 15));
      tick("handshake");
    end
    req_valid = 1'b0;
    for (int n = 0; n < 25; n++) tick("drain");

    // Reset asserted mid-HOLD aborts the press immediately.
    req_key   = 4'h9;
    key_c     = 4'b1101;
    req_valid = 1'b1;
    tick("midhold");
    req_valid = 1'b0;
    for (int n = 0; n < 6; n++) tick("midhold");
    #2 clr = 1'b1;
    #1 model_reset();
    check_all("midhold_clr");
    @(negedge clk);
    clr = 1'b0;
    press_and_time(4'h5, 4'b1101, "after_clr");

    // Randomized traffic with occasional resets at clock edges.
    for (int n = 0; n < 500; n++) begin
      req_valid = ($urandom_range(0, 2) != 0);
      req_key   = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1) key_c = ~(4'b0001 << $urandom_range(0, 3));
      else key_c = 4'($urandom_range(0, 15));
      clr = ($urandom_range(0, 149) == 0);
      tick("random");
    end
    clr       = 1'b0;
    req_valid = 1'b0;
    for (int n = 0; n < 25; n++) tick("final");

    for (int i = 0; i < 3; i++)
      chk($sformatf("done_count_i%0d", i), obs_dones[i], exp_dones[i]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
